// File: rtl/pred_pkg.sv
// ---------------------------------------------------------------------------
// pred_pkg : shared state encoding and defaults for prediction_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pred_pkg;

  localparam int CLASSES_DEF = 10;
  localparam int SCORE_W_DEF = 8;
  localparam int CLASS_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } pred_state_t;

endpackage

`default_nettype wire

// File: rtl/pred_max_tracker.sv
// ---------------------------------------------------------------------------
// pred_max_tracker : running best (and, with PRED_MARGIN_EN, second-best) score
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pred_max_tracker
  import pred_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_load,
  input  logic                   i_first,
  input  logic [CLASS_IDX_W-1:0] i_idx,
  input  logic [SCORE_W-1:0]     i_score,
  output logic [SCORE_W-1:0]     o_best_score,
  output logic [CLASS_IDX_W-1:0] o_best_idx
`ifdef PRED_MARGIN_EN
  ,
  output logic [SCORE_W-1:0]     o_second_score
`endif
);

  logic [SCORE_W-1:0]     r_best_score;
  logic [CLASS_IDX_W-1:0] r_best_idx;
  logic                   w_take;

  // Strictly-greater replacement keeps the lowest index on ties.
  assign w_take = i_first || (i_score > r_best_score);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_score <= '0;
      r_best_idx   <= '0;
    end else if (i_clear) begin
      r_best_score <= '0;
      r_best_idx   <= '0;
    end else if (i_load && w_take) begin
      r_best_score <= i_score;
      r_best_idx   <= i_idx;
    end
  end

`ifdef PRED_MARGIN_EN
  logic [SCORE_W-1:0] r_second_score;

  // A score equal to the best falls through to the second-best update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_second_score <= '0;
    end else if (i_clear) begin
      r_second_score <= '0;
    end else if (i_load) begin
      if (i_first)
        r_second_score <= '0;
      else if (i_score > r_best_score)
        r_second_score <= r_best_score;
      else if (i_score > r_second_score)
        r_second_score <= i_score;
    end
  end

  assign o_second_score = r_second_score;
`endif

  assign o_best_score = r_best_score;
  assign o_best_idx   = r_best_idx;

endmodule

`default_nettype wire

// File: rtl/prediction_sequencer.sv
// ---------------------------------------------------------------------------
// prediction_sequencer : collects CLASSES scores and reports the argmax class.
// Optional macro PRED_MARGIN_EN adds pred_margin (best minus second-best).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prediction_sequencer
  import pred_pkg::*;
#(
  parameter int CLASSES = CLASSES_DEF,
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               score_valid,
  output logic               score_ready,
  input  logic [SCORE_W-1:0] score_data,
  output logic               busy,
  output logic               pred_valid,
  input  logic               pred_ready,
  output logic [7:0]         pred_class,
  output logic [SCORE_W-1:0] pred_score
`ifdef PRED_MARGIN_EN
  ,
  output logic [SCORE_W-1:0] pred_margin
`endif
);

  generate
    if (CLASSES < 2 || CLASSES > 256) begin : g_bad_classes
      $error("prediction_sequencer: CLASSES must be in 2..256");
    end
  endgenerate

  localparam logic [CLASS_IDX_W-1:0] LAST_IDX = CLASS_IDX_W'(CLASSES - 1);

  pred_state_t            r_state;
  pred_state_t            w_next;
  logic [CLASS_IDX_W-1:0] r_count;
  logic                   w_clear;
  logic                   w_accept;
  logic                   w_last;
  logic [SCORE_W-1:0]     w_best_score;
  logic [CLASS_IDX_W-1:0] w_best_idx;

  assign w_clear  = (r_state == IDLE) && start;
  assign w_accept = (r_state == COLLECT) && score_valid;
  assign w_last   = (r_count == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    score_ready = 1'b0;
    busy        = 1'b1;
    pred_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = COLLECT;
      end
      COLLECT: begin
        score_ready = 1'b1;
        if (w_accept && w_last) w_next = HOLD;
      end
      HOLD: begin
        pred_valid = 1'b1;
        if (pred_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter parks on the last index rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_count <= '0;
    else if (w_clear)             r_count <= '0;
    else if (w_accept && !w_last) r_count <= r_count + 1'b1;
  end

`ifdef PRED_MARGIN_EN
  logic [SCORE_W-1:0] w_second_score;
`endif

  pred_max_tracker #(
    .SCORE_W (SCORE_W)
  ) u_tracker (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (w_clear),
    .i_load         (w_accept),
    .i_first        (r_count == '0),
    .i_idx          (r_count),
    .i_score        (score_data),
    .o_best_score   (w_best_score),
    .o_best_idx     (w_best_idx)
`ifdef PRED_MARGIN_EN
    ,
    .o_second_score (w_second_score)
`endif
  );

  assign pred_class = w_best_idx;
  assign pred_score = w_best_score;
`ifdef PRED_MARGIN_EN
  assign pred_margin = w_best_score - w_second_score;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prediction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prediction_sequencer : scoreboard bench for prediction_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prediction_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       score_valid;
  logic       score_ready;
  logic [7:0] score_data;
  logic       busy;
  logic       pred_valid;
  logic       pred_ready;
  logic [7:0] pred_class;
  logic [7:0] pred_score;
`ifdef PRED_MARGIN_EN
  logic [7:0] pred_margin;
`endif

  prediction_sequencer #(
    .CLASSES (10),
    .SCORE_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .score_data  (score_data),
    .busy        (busy),
    .pred_valid  (pred_valid),
    .pred_ready  (pred_ready),
    .pred_class  (pred_class),
    .pred_score  (pred_score)
`ifdef PRED_MARGIN_EN
    ,
    .pred_margin (pred_margin)
`endif
  );

  typedef struct {
    logic [7:0] cls;
    logic [7:0] score;
    logic [7:0] margin;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] stim[10];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         t0 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void push_expected();
    exp_t e;
    int   bi  = 0;
    int   sec = 0;
    for (int i = 1; i < 10; i++) if (stim[i] > stim[bi]) bi = i;
    for (int i = 0; i < 10; i++) if (i != bi && int'(stim[i]) > sec) sec = int'(stim[i]);
    e.cls    = 8'(bi);
    e.score  = stim[bi];
    e.margin = stim[bi] - 8'(sec);
    sb.push_back(e);
  endfunction

  task automatic start_inf();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps, input int n);
    int g;
    bit rdy;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        score_valid = 1'b0;
        score_data  = 8'hEE;
        @(negedge clk);
      end
      score_valid = 1'b1;
      score_data  = stim[i];
      g   = 0;
      rdy = 1'b0;
      while (!rdy && g < 50) begin
        rdy = score_ready;
        @(negedge clk);
        g++;
      end
      if (!rdy) begin
        n_checks++; n_errors++;
        $display("FAIL score_ready_timeout: index %0d never accepted", i);
      end
    end
    score_valid = 1'b0;
  endtask

  task automatic wait_pred(input bit check_lat);
    int g = 0;
    while (pred_valid !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (pred_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL pred_valid_timeout: got %b want 1", pred_valid);
      return;
    end
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got pred_valid with no expected result");
      return;
    end
    cur = sb.pop_front();
    n_checks++;
    if (pred_class !== cur.cls) begin
      n_errors++;
      $display("FAIL pred_class: got %0d want %0d", pred_class, cur.cls);
    end
    n_checks++;
    if (pred_score !== cur.score) begin
      n_errors++;
      $display("FAIL pred_score: got %0d want %0d", pred_score, cur.score);
    end
`ifdef PRED_MARGIN_EN
    n_checks++;
    if (pred_margin !== cur.margin) begin
      n_errors++;
      $display("FAIL pred_margin: got %0d want %0d", pred_margin, cur.margin);
    end
`endif
    if (check_lat) begin
      n_checks++;
      if (cyc - t0 != 11) begin
        n_errors++;
        $display("FAIL latency: got %0d want 11", cyc - t0);
      end
    end
  endtask

  task automatic release_pred(input int hold_cycles, input bit pulse_start);
    for (int i = 0; i < hold_cycles; i++) begin
      pred_ready = 1'b0;
      start      = pulse_start && (i == hold_cycles / 2);
      @(negedge clk);
      n_checks++;
      if (pred_valid !== 1'b1 || busy !== 1'b1 || pred_class !== cur.cls || pred_score !== cur.score) begin
        n_errors++;
        $display("FAIL hold_stable: cycle %0d got v=%b b=%b c=%0d s=%0d want v=1 b=1 c=%0d s=%0d",
                 i, pred_valid, busy, pred_class, pred_score, cur.cls, cur.score);
      end
    end
    pred_ready = 1'b1;
    start      = pulse_start;
    @(negedge clk);
    n_checks++;
    if (pred_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL release_idle: got v=%b b=%b want v=0 b=0", pred_valid, busy);
    end
    pred_ready = 1'b0;
    start      = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_not_queued: got busy=%b want 0", busy);
    end
  endtask

  task automatic do_inference(input bit gaps, input bit check_lat, input int hold_cycles, input bit pulse);
    push_expected();
    start_inf();
    feed(gaps, 10);
    wait_pred(check_lat);
    release_pred(hold_cycles, pulse);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (score_ready !== 1'b0 || busy !== 1'b0 || pred_valid !== 1'b0 || pred_class !== 8'd0 || pred_score !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_state: got r=%b b=%b v=%b c=%0d s=%0d want all 0",
               score_ready, busy, pred_valid, pred_class, pred_score);
    end
    stim = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd90, 8'd50, 8'd60, 8'd70, 8'd80, 8'd15};
    push_expected();
    rst_n = 1'b1;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL first_start: got busy=%b want 1", busy);
    end
    feed(1'b0, 10);
    wait_pred(1'b1);
    release_pred(0, 1'b0);
  endtask

  task automatic test_basic();
    stim = '{8'd3, 8'd9, 8'd1, 8'd0, 8'd7, 8'd2, 8'd5, 8'd8, 8'd4, 8'd6};
    do_inference(1'b0, 1'b1, 2, 1'b0);
  endtask

  task automatic test_ties();
    stim = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    do_inference(1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_gaps();
    stim = '{8'd100, 8'd3, 8'd199, 8'd4, 8'd150, 8'd6, 8'd7, 8'd8, 8'd9, 8'd200};
    do_inference(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_hold();
    stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd77, 8'd8, 8'd9, 8'd10};
    do_inference(1'b0, 1'b1, 20, 1'b1);
  endtask

  task automatic test_reset_mid();
    stim = '{8'd40, 8'd50, 8'd60, 8'd70, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    start_inf();
    feed(1'b0, 4);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (score_ready !== 1'b0 || busy !== 1'b0 || pred_valid !== 1'b0 || pred_class !== 8'd0 || pred_score !== 8'd0) begin
      n_errors++;
      $display("FAIL async_reset: got r=%b b=%b v=%b c=%0d s=%0d want all 0",
               score_ready, busy, pred_valid, pred_class, pred_score);
    end
`ifdef PRED_MARGIN_EN
    n_checks++;
    if (pred_margin !== 8'd0) begin
      n_errors++;
      $display("FAIL async_reset_margin: got %0d want 0", pred_margin);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (pred_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_discard: got pred_valid=%b want 0", pred_valid);
    end
    stim = '{8'd10, 8'd20, 8'd250, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    do_inference(1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_idle_scores();
    score_valid = 1'b1;
    score_data  = 8'd255;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (score_ready !== 1'b0 || busy !== 1'b0 || pred_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_scores: got r=%b b=%b v=%b want 0 0 0", score_ready, busy, pred_valid);
      end
    end
    score_valid = 1'b0;
    stim = '{8'd11, 8'd12, 8'd13, 8'd99, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19, 8'd20};
    do_inference(1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10; i++) stim[i] = 8'($urandom_range(0, 255));
      do_inference(k[0], 1'b0, 0, 1'b0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    score_valid = 1'b0;
    score_data  = 8'd0;
    pred_ready  = 1'b0;
    test_reset();
    test_basic();
    test_ties();
    test_gaps();
    test_hold();
    test_reset_mid();
    test_idle_scores();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prediction_sequencer.md
PREDICTION_SEQUENCER -- requirements
Module: prediction_sequencer

Interface
REQ-001 Parameter CLASSES, default 10, number of class scores per inference; legal range 2..256, elaboration error otherwise.
REQ-002 Parameter SCORE_W, default 8, unsigned score width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin one inference; honoured only in IDLE.
REQ-006 score_valid  input  1  score_data holds a class score.
REQ-007 score_ready  output  1  block accepts a score this cycle.
REQ-008 score_data  input  SCORE_W  unsigned score, class order 0..CLASSES-1.
REQ-009 busy  output  1  state is not IDLE.
REQ-010 pred_valid  output  1  result available.
REQ-011 pred_ready  input  1  consumer accepts result.
REQ-012 pred_class  output  8  winning class index, zero-extended.
REQ-013 pred_score  output  SCORE_W  winning score.
REQ-014 pred_margin  output  SCORE_W  best minus second-best score; present only with PRED_MARGIN_EN.

Function
REQ-015 FSM states IDLE, COLLECT, HOLD; score_ready=1 only in COLLECT; pred_valid=1 only in HOLD.
REQ-016 IDLE: start=1 -> COLLECT next cycle; index counter, best score and best index cleared.
REQ-017 COLLECT: score consumed on score_valid&score_ready; index counter increments by 1 per handshake, no wrap.
REQ-018 Score at index 0 loads best score/index unconditionally; later scores replace best only if strictly greater, so ties keep the lowest index.
REQ-019 Handshake at index CLASSES-1 -> HOLD next cycle; pred_valid rises the cycle after the final score handshake.
REQ-020 Minimum latency start-to-pred_valid is CLASSES+1 cycles with score_valid held high; score_valid gaps stall without loss.
REQ-021 HOLD: pred_class, pred_score, pred_margin stable until pred_ready=1; then IDLE next cycle, pred_valid low that cycle.
REQ-022 start while busy=1 ignored, including same cycle as pred_ready in HOLD; no queued start.
REQ-023 Scores presented outside COLLECT are not consumed and do not affect state.

Reset
REQ-024 rst_n low: state IDLE, score_ready=0, busy=0, pred_valid=0, pred_class=0, pred_score=0, pred_margin=0, counter=0, immediately and asynchronously.
REQ-025 Reset mid-COLLECT or mid-HOLD discards partial/held result; no pred_valid until a new full inference completes.
REQ-026 Reset deassertion synchronous to clk; first start is honoured on the first rising edge with rst_n high.

Configuration
REQ-027 Macro PRED_MARGIN_EN defined: second-best score tracked (updated on every consumed score, ties with best count as second), pred_margin = best - second, 0 on ties.
REQ-028 Macro PRED_MARGIN_EN undefined: pred_margin port and second-best register absent; all other behaviour identical.

Structure
REQ-029 Shared package pred_pkg holds pred_state_t enum (IDLE, COLLECT, HOLD), CLASSES_DEF=10, SCORE_W_DEF=8, CLASS_IDX_W=8.
REQ-030 One sub-module pred_max_tracker holds best/second-best compare-and-update registers; FSM and counter stay in prediction_sequencer.

Verification
REQ-031 Scores 3,9,1,0,7,2,5,8,4,6 back-to-back -> pred_class=1, pred_score=9, pred_valid 11 cycles after start; margin=1 with macro.
REQ-032 Scores 5,5,5,5,5,5,5,5,5,5 -> pred_class=0, pred_score=5, margin=0.
REQ-033 Max 200 at index 9, score_valid toggled every other cycle -> pred_class=9, pred_score=200, no lost scores.
REQ-034 pred_ready held low 20 cycles in HOLD, start pulsed -> outputs stable, start ignored, IDLE one cycle after pred_ready.
REQ-035 rst_n low after 4 scores -> all outputs 0 immediately; new inference with max at index 2 -> pred_class=2.
REQ-036 score_valid high while IDLE, no start -> score_ready=0, busy=0, no pred_valid.
